// File: rtl/dsp_job_scheduler.sv
// Job sequencer for the ping-pong input buffer: queues full blocks, runs FIR or FFT(/IFFT),
// then DMA-out, with a per-stage watchdog and overrun accounting.
module dsp_job_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready_for_processing,
    input  logic       buffer_select,
    output logic       ready_ack,
    input  logic [4:0] config_mode,
    output logic       start_fir,
    output logic       start_fft,
    output logic       start_ifft,
    output logic       start_dma_out,
    input  logic       fir_done,
    input  logic       fft_done,
    input  logic       ifft_done,
    input  logic       dma_done,
    output logic       active_buffer,
    output logic       processing_active,
    output logic       job_done,
    output logic       timeout_err,
    output logic [7:0] overrun_count,
    input  logic       clear_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_FIR   = 3'd2,
        WAIT_FFT   = 3'd3,
        WAIT_IFFT  = 3'd4,
        DMA_LAUNCH = 3'd5,
        WAIT_DMA   = 3'd6
    } state_t;

    state_t state, state_next;

    logic                 rfp_q, armed;
    logic                 fir_q, fft_q, ifft_q, dma_q;
    logic                 fir_rise, fft_rise, ifft_rise, dma_rise;
    logic                 rfp_rise, req, pop, can_push, push, overrun_inc;
    logic [1:0]           count;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           q_mem;
    logic [1:0]           mode_q;
    logic                 is_fft;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 in_wait, done_hit, timeout_hit;
    logic                 start_fir_d, start_fft_d, start_ifft_d, start_dma_d, job_done_d;
    logic                 unused_mode_bits;

    assign unused_mode_bits = ^config_mode[4:2];

    assign rfp_rise    = ready_for_processing & ~rfp_q;
    assign req         = ready_for_processing & (rfp_rise | armed);
    assign pop         = (state == IDLE) && (count != 2'd0);
    assign can_push    = (count < 2'd2) || pop;
    assign push        = req & can_push;
    assign overrun_inc = rfp_rise & ~can_push;

    assign fir_rise  = fir_done  & ~fir_q;
    assign fft_rise  = fft_done  & ~fft_q;
    assign ifft_rise = ifft_done & ~ifft_q;
    assign dma_rise  = dma_done  & ~dma_q;

    // Edge registers reset high so an input already high across reset release is not seen as new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rfp_q  <= 1'b1;
            fir_q  <= 1'b1;
            fft_q  <= 1'b1;
            ifft_q <= 1'b1;
            dma_q  <= 1'b1;
            armed  <= 1'b0;
        end else begin
            rfp_q  <= ready_for_processing;
            fir_q  <= fir_done;
            fft_q  <= fft_done;
            ifft_q <= ifft_done;
            dma_q  <= dma_done;
            armed  <= req & ~push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_mem  <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= buffer_select;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign is_fft  = mode_q[1] ^ mode_q[0];
    assign in_wait = (state == WAIT_FIR) || (state == WAIT_FFT) ||
                     (state == WAIT_IFFT) || (state == WAIT_DMA);

    always_comb begin
        done_hit = 1'b0;
        case (state)
            WAIT_FIR:  done_hit = fir_rise;
            WAIT_FFT:  done_hit = fft_rise;
            WAIT_IFFT: done_hit = ifft_rise;
            WAIT_DMA:  done_hit = dma_rise;
            default:   done_hit = 1'b0;
        endcase
    end

    assign timeout_hit = in_wait && !done_hit && (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (pop) state_next = LAUNCH;
            LAUNCH:     state_next = is_fft ? WAIT_FFT : WAIT_FIR;
            WAIT_FIR:   if (fir_rise) state_next = DMA_LAUNCH;
                        else if (timeout_hit) state_next = IDLE;
            WAIT_FFT:   if (fft_rise) state_next = (mode_q == 2'b01) ? WAIT_IFFT : DMA_LAUNCH;
                        else if (timeout_hit) state_next = IDLE;
            WAIT_IFFT:  if (ifft_rise) state_next = DMA_LAUNCH;
                        else if (timeout_hit) state_next = IDLE;
            DMA_LAUNCH: state_next = WAIT_DMA;
            WAIT_DMA:   if (dma_rise || timeout_hit) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        start_fir_d  = (state == LAUNCH) && !is_fft;
        start_fft_d  = (state == LAUNCH) && is_fft;
        start_ifft_d = (state == WAIT_FFT) && fft_rise && (mode_q == 2'b01);
        start_dma_d  = (state == DMA_LAUNCH);
        job_done_d   = (state == WAIT_DMA) && dma_rise;
    end

    // Watchdog restarts on every state change so each WAIT state gets its own budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             wd_cnt <= '0;
        else if (in_wait && state_next == state) wd_cnt <= wd_cnt + 1'b1;
        else                                    wd_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_buffer <= 1'b0;
            mode_q        <= 2'b00;
        end else if (pop) begin
            active_buffer <= q_mem[rd_ptr];
            mode_q        <= config_mode[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_fir     <= 1'b0;
            start_fft     <= 1'b0;
            start_ifft    <= 1'b0;
            start_dma_out <= 1'b0;
            job_done      <= 1'b0;
            ready_ack     <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_count <= 8'd0;
        end else begin
            start_fir     <= start_fir_d;
            start_fft     <= start_fft_d;
            start_ifft    <= start_ifft_d;
            start_dma_out <= start_dma_d;
            job_done      <= job_done_d;
            ready_ack     <= push;
            if (timeout_hit)    timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
            if (clear_err)                              overrun_count <= 8'd0;
            else if (overrun_inc && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end
    end

    assign processing_active = (state != IDLE);
    assign state_dbg         = state;

endmodule

// File: tb/tb_dsp_job_scheduler.sv
// Directed bench for dsp_job_scheduler: FIR, FFT/IFFT, queueing, overrun, watchdog and reset cases.
module tb_dsp_job_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rfp = 1'b0, bs = 1'b0, clear_err = 1'b0;
    logic       fir_done = 1'b0, fft_done = 1'b0, ifft_done = 1'b0, dma_done = 1'b0;
    logic [4:0] config_mode = 5'd0;
    logic       ready_ack, start_fir, start_fft, start_ifft, start_dma_out;
    logic       active_buffer, processing_active, job_done, timeout_err;
    logic [7:0] overrun_count;
    logic [2:0] state_dbg;

    int tests = 0, fails = 0;
    int n_fir = 0, n_fft = 0, n_ifft = 0, n_dma = 0, n_jd = 0, n_ack = 0;
    int c0, c1, c2, c3;

    always #5 clk = ~clk;

    dsp_job_scheduler #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .ready_for_processing(rfp), .buffer_select(bs), .ready_ack(ready_ack),
        .config_mode(config_mode),
        .start_fir(start_fir), .start_fft(start_fft), .start_ifft(start_ifft),
        .start_dma_out(start_dma_out),
        .fir_done(fir_done), .fft_done(fft_done), .ifft_done(ifft_done), .dma_done(dma_done),
        .active_buffer(active_buffer), .processing_active(processing_active),
        .job_done(job_done), .timeout_err(timeout_err), .overrun_count(overrun_count),
        .clear_err(clear_err), .state_dbg(state_dbg)
    );

    // Pulse counters sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (start_fir)     n_fir++;
        if (start_fft)     n_fft++;
        if (start_ifft)    n_ifft++;
        if (start_dma_out) n_dma++;
        if (job_done)      n_jd++;
        if (ready_ack)     n_ack++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b);
        rfp = 1'b1;
        bs  = b;
        tick();
    endtask

    function automatic int allOutputs();
        return int'({ready_ack, start_fir, start_fft, start_ifft, start_dma_out, active_buffer,
                     processing_active, job_done, timeout_err, overrun_count, state_dbg});
    endfunction

    // From the start_fir cycle: finish FIR, expect DMA two cycles after the done, then job_done.
    task automatic runJobTail(input string tag);
        fir_done = 1'b1; tick(); fir_done = 1'b0;
        tick();
        checkOutput({tag, "_dma"}, int'(start_dma_out), 1);
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        checkOutput({tag, "_done"}, int'(job_done), 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        #3;
        checkOutput("reset_outputs", allOutputs(), 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // FIR job, buffer A
        c0 = n_fft; c1 = n_ifft;
        config_mode = 5'b00000;
        applyStimulus(1'b0);
        checkOutput("fir_ack", int'(ready_ack), 1);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("fir_start", int'(start_fir), 1);
        checkOutput("fir_state", int'(state_dbg), 2);
        checkOutput("fir_active", int'(processing_active), 1);
        tick();
        fir_done = 1'b1; tick(); fir_done = 1'b0;
        checkOutput("fir_dma_launch", int'(state_dbg), 5);
        tick();
        checkOutput("fir_dma", int'(start_dma_out), 1);
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        checkOutput("fir_job_done", int'(job_done), 1);
        checkOutput("fir_buf", int'(active_buffer), 0);
        tick();
        checkOutput("fir_done_width", int'(job_done), 0);
        checkOutput("fir_no_fft", n_fft - c0, 0);
        checkOutput("fir_no_ifft", n_ifft - c1, 0);

        // FFT then IFFT, buffer B; mode changed mid-job and a stray fir_done
        config_mode = 5'b00001;
        applyStimulus(1'b1);
        checkOutput("chain_ack", int'(ready_ack), 1);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("chain_fft", int'(start_fft), 1);
        checkOutput("chain_state", int'(state_dbg), 3);
        config_mode = 5'b11100;
        fir_done = 1'b1; tick(); fir_done = 1'b0;
        checkOutput("stray_fir", int'(state_dbg), 3);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        checkOutput("chain_ifft", int'(start_ifft), 1);
        checkOutput("chain_ifft_state", int'(state_dbg), 4);
        tick();
        ifft_done = 1'b1; tick(); ifft_done = 1'b0;
        checkOutput("chain_dma_launch", int'(state_dbg), 5);
        tick();
        checkOutput("chain_dma", int'(start_dma_out), 1);
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        checkOutput("chain_job_done", int'(job_done), 1);
        checkOutput("chain_buf", int'(active_buffer), 1);

        // FFT only
        c0 = n_ifft;
        config_mode = 5'b00010;
        applyStimulus(1'b0);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("fftonly_fft", int'(start_fft), 1);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        checkOutput("fftonly_state", int'(state_dbg), 5);
        tick();
        checkOutput("fftonly_dma", int'(start_dma_out), 1);
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        checkOutput("fftonly_done", int'(job_done), 1);
        checkOutput("fftonly_no_ifft", n_ifft - c0, 0);

        // Queue and overrun: job on B in flight, then A, B, A
        config_mode = 5'b00000;
        applyStimulus(1'b1);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("q_job0_start", int'(start_fir), 1);
        applyStimulus(1'b0);
        checkOutput("q_ack1", int'(ready_ack), 1);
        rfp = 1'b0; tick();
        applyStimulus(1'b1);
        checkOutput("q_ack2", int'(ready_ack), 1);
        rfp = 1'b0; tick();
        applyStimulus(1'b0);
        checkOutput("q_noack3", int'(ready_ack), 0);
        checkOutput("q_ovr1", int'(overrun_count), 1);
        tick();
        checkOutput("q_ovr_once", int'(overrun_count), 1);
        fir_done = 1'b1; tick(); fir_done = 1'b0;
        tick();
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        checkOutput("q_job0_done", int'(job_done), 1);
        checkOutput("q_noack_at_done", int'(ready_ack), 0);
        tick();
        checkOutput("q_ack3", int'(ready_ack), 1);
        rfp = 1'b0;
        tick();
        checkOutput("q_job1_start", int'(start_fir), 1);
        checkOutput("q_job1_buf", int'(active_buffer), 0);
        runJobTail("q_job1");
        tick(); tick();
        checkOutput("q_job2_start", int'(start_fir), 1);
        checkOutput("q_job2_buf", int'(active_buffer), 1);
        runJobTail("q_job2");
        tick(); tick();
        checkOutput("q_job3_start", int'(start_fir), 1);
        checkOutput("q_job3_buf", int'(active_buffer), 0);
        runJobTail("q_job3");
        tick(); tick(); tick();
        checkOutput("q_idle", int'(state_dbg), 0);

        // Watchdog: fft_done withheld, second block queued behind the aborted job
        config_mode = 5'b00001;
        applyStimulus(1'b0);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("to_fft", int'(start_fft), 1);
        c0 = n_dma; c1 = n_jd;
        applyStimulus(1'b1);
        checkOutput("to_queue_ack", int'(ready_ack), 1);
        rfp = 1'b0;
        config_mode = 5'b00000;
        repeat (14) tick();
        checkOutput("to_not_early", int'(timeout_err), 0);
        checkOutput("to_still_wait", int'(state_dbg), 3);
        tick();
        checkOutput("to_set", int'(timeout_err), 1);
        checkOutput("to_idle", int'(state_dbg), 0);
        tick(); tick();
        checkOutput("to_next_start", int'(start_fir), 1);
        checkOutput("to_next_buf", int'(active_buffer), 1);
        checkOutput("to_no_dma", n_dma - c0, 0);
        checkOutput("to_no_job_done", n_jd - c1, 0);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        checkOutput("to_cleared", int'(timeout_err), 0);
        checkOutput("ovr_cleared", int'(overrun_count), 0);
        runJobTail("to_next");
        tick();

        // Reset in WAIT_DMA with one block queued and ready_for_processing held high
        applyStimulus(1'b0);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("rst_start", int'(start_fir), 1);
        applyStimulus(1'b1);
        checkOutput("rst_ack2", int'(ready_ack), 1);
        tick();
        fir_done = 1'b1; tick(); fir_done = 1'b0;
        tick();
        checkOutput("rst_in_wait_dma", int'(state_dbg), 6);
        #2 reset = 1'b0;
        #1 checkOutput("rst_async_clear", allOutputs(), 0);
        tick(); tick();
        reset = 1'b1;
        c0 = n_fir; c1 = n_fft; c2 = n_ack; c3 = n_dma;
        repeat (20) tick();
        checkOutput("rst_no_fir", n_fir - c0, 0);
        checkOutput("rst_no_fft", n_fft - c1, 0);
        checkOutput("rst_no_ack", n_ack - c2, 0);
        checkOutput("rst_no_dma", n_dma - c3, 0);
        checkOutput("rst_idle", int'(state_dbg), 0);
        rfp = 1'b0; tick();
        applyStimulus(1'b1);
        checkOutput("rst_new_ack", int'(ready_ack), 1);
        rfp = 1'b0;
        tick(); tick();
        checkOutput("rst_new_start", int'(start_fir), 1);
        runJobTail("rst_new");
        tick();

        // Overrun saturation: many edges while the queue keeps filling and jobs time out
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0);
            rfp = 1'b0;
            tick();
        end
        checkOutput("ovr_sat", int'(overrun_count), 255);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        checkOutput("ovr_sat_clear", int'(overrun_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
